// File: rtl/mips_cpu_ifetch.sv
// Instruction-fetch front end.
// Issues one Avalon-style word read per instruction to instruction memory,
// holds the returned word for decode, and tells the PC unit when the held
// instruction has been consumed (pc_en) so the PC advances in lockstep.
// There is no prefetch: a new read is issued only after the previous
// instruction has been consumed or discarded.
module mips_cpu_ifetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic [31:0] pc_in,
  input  logic        active,
  input  logic        instr_ready,
  input  logic        flush,
  output logic [31:0] address,
  output logic        read,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        pc_en,
  output logic        fetch_err
);

  // IDLE : waiting to issue a read from pc_in
  // REQ  : read outstanding, result will be kept
  // HOLD : instruction captured, waiting for decode to take it
  // DRAIN: read outstanding after a flush, result will be dropped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] address_nxt;
  logic        read_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] instr_pc_nxt;
  logic        instr_valid_nxt;
  logic        fetch_err_nxt;

  // Next-state and next-output decode for the fetch FSM.
  always_comb begin
    // NOTE: every signal assigned here starts from a default (its current
    // value) so no path through the case leaves it unassigned and no latch
    // is inferred.
    state_nxt       = state;
    address_nxt     = address;
    read_nxt        = read;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;
    fetch_err_nxt   = fetch_err;

    unique case (state)
      IDLE: begin
        // flush has nothing to discard here, so it is ignored.
        if (active) begin
          if (pc_in[1:0] != 2'b00) begin
            // Sticky until reset: the CPU cannot recover from a bad PC.
            fetch_err_nxt = 1'b1;
          end else if (!fetch_err) begin
            address_nxt = {pc_in[31:2], 2'b00};
            read_nxt    = 1'b1;
            state_nxt   = REQ;
          end
        end
      end

      REQ: begin
        // address/read stay put while the slave stalls; pc_in is ignored.
        if (!waitrequest) begin
          read_nxt = 1'b0;
          if (flush) begin
            // Data arrives in the same cycle as the flush: drop it.
            state_nxt = IDLE;
          end else begin
            instr_nxt       = readdata;
            instr_pc_nxt    = address;
            instr_valid_nxt = 1'b1;
            state_nxt       = HOLD;
          end
        end else if (flush) begin
          // A stalled Avalon read cannot be withdrawn; finish it and discard.
          state_nxt = DRAIN;
        end
      end

      HOLD: begin
        // flush takes priority over a simultaneous consume.
        if (flush) begin
          instr_valid_nxt = 1'b0;
          instr_nxt       = NOP_WORD;
          state_nxt       = IDLE;
        end else if (instr_ready) begin
          instr_valid_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end

      DRAIN: begin
        if (!waitrequest) begin
          read_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        read_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      address     <= '0;
      read        <= 1'b0;
      instr       <= NOP_WORD;
      instr_pc    <= RESET_VECTOR;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      state       <= state_nxt;
      address     <= address_nxt;
      read        <= read_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
      fetch_err   <= fetch_err_nxt;
    end
  end

  // Consume handshake back to the PC unit; a flush suppresses the advance.
  assign pc_en      = instr_valid && instr_ready && !flush;

  // Always whole-word reads.
  assign byteenable = 4'b1111;

endmodule
